mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
Shared-RAM controller for the pipelined MIPS core. Arbitrates the single RAM port between the icache (read-only) and the dcache (read/write, word-at-a-time block fills, writebacks and halt flush). Sequences each RAM transaction and returns a one-cycle completion strobe to the granted cache. Dcache has priority; a bounded-streak rule prevents icache starvation.

Parameters:
WORD_W, 32, data/address width
MAX_DSTREAK, 4, consecutive dcache completions allowed while icache waits before icache is forced next (1..15)

Ports:
CLK  in  1  clock
nRST  in  1  reset; single clock, reset asynchronous and active-low
iREN  in  1  icache read request
iaddr  in  WORD_W  icache word address
iwait  out  1  0 only in the icache completion cycle
iload  out  WORD_W  read data to icache
dREN  in  1  dcache read request
dWEN  in  1  dcache write request (wins over dREN)
daddr  in  WORD_W  dcache word address
dstore  in  WORD_W  dcache write data
dwait  out  1  0 only in the dcache completion cycle
dload  out  WORD_W  read data to dcache
ramREN  out  1  RAM read enable
ramWEN  out  1  RAM write enable
ramaddr  out  WORD_W  RAM address
ramstore  out  WORD_W  RAM write data
ramload  in  WORD_W  RAM read data
ramstate  in  2  0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR

Behaviour:
- Owner register: states IDLE, DGNT, IGNT. Reset -> IDLE, streak=0; iwait=dwait=1, ramREN=ramWEN=0, ramaddr=ramstore=0.
- IDLE: no RAM enables. Next state: DGNT if (dREN|dWEN) and not (iREN and streak==MAX_DSTREAK); else IGNT if iREN; else DGNT if (dREN|dWEN); else IDLE. Arbitration costs exactly one cycle.
- DGNT: ramaddr=daddr; ramWEN=dWEN; ramREN=dREN&!dWEN; ramstore=dWEN?dstore:0. When ramstate==ACCESS: dwait=0 that cycle, -> IDLE.
- IGNT: ramaddr=iaddr; ramREN=1; ramWEN=0; ramstore=0. When ramstate==ACCESS: iwait=0 that cycle, -> IDLE.
- FREE/BUSY/ERROR in a grant state: hold state, enables and address; wait stays 1. ERROR is never surfaced as completion.
- Requester drops its request while granted (enables both 0): abandon -> IDLE next cycle, no completion strobe, RAM enables 0 that cycle.
- iload=dload=ramload combinationally at all times; consumers sample only when their wait=0.
- Requesters hold address/data stable until their wait falls; controller does not latch them.
- streak: on dcache completion, streak=min(streak+1,MAX_DSTREAK) if iREN==1, else 0. On icache completion, streak=0. Forced icache grant happens only at IDLE.
- Minimum transaction: IDLE, grant, completion (ACCESS in first grant cycle) = 2 cycles; back-to-back block fill words each pay the IDLE cycle.
- nRST assertion mid-transaction: immediate return to reset values; no partial completion strobe.

Optional Feature:
ARB_STATS_EN: adds outputs icount, dcount, stallcount (each 32-bit, reset 0). icount/dcount increment on each icache/dcache completion; stallcount increments every cycle iREN==1 and iwait==1 while owner is DGNT or IDLE. Counters wrap at 2^32. Without the macro these ports and registers do not exist; arbitration is unchanged.

Test Plan:
- Reset with iREN=1, ramstate=ACCESS -> iwait=dwait=1, ramREN=ramWEN=0 until first posedge after nRST release; IGNT next cycle.
- iREN=1, iaddr=0x40, ramstate BUSY 2 cycles then ACCESS, ramload=0xDEADBEEF -> ramREN=1, ramaddr=0x40 through grant; iwait=0 for exactly 1 cycle with iload=0xDEADBEEF.
- iREN=1 and dWEN=1 same cycle, daddr=0x80, dstore=0x12345678 -> DGNT first, ramWEN=1, ramstore=0x12345678; icache served after dcache completion.
- dREN held continuously with iREN=1, MAX_DSTREAK=4, ramstate always ACCESS -> 4 dcache completions, then 1 icache completion, streak=0, then dcache resumes.
- dREN=1 and dWEN=1 together -> ramWEN=1, ramREN=0; ramstate=ERROR 3 cycles then ACCESS -> dwait stays 1 during ERROR, drops once.
- dREN dropped mid-DGNT (ramstate BUSY) -> IDLE next cycle, dwait never 0; with ARB_STATS_EN dcount unchanged.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shared-RAM controller for the pipelined MIPS core.
// One RAM port is shared by the icache (read-only) and the dcache (read/write).
// The dcache has priority. After MAX_DSTREAK back-to-back dcache completions
// while the icache is waiting, the icache is granted next so it cannot starve.
// Every transaction spends one arbitration cycle in IDLE. The granted cache
// then gets a one-cycle completion strobe (its wait output drops to 0).
// Optional feature: define ARB_STATS_EN to add the icount, dcount and
// stallcount statistics outputs.
module mem_arbiter #(
  parameter int unsigned WORD_W      = 32,
  parameter int unsigned MAX_DSTREAK = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  output logic              iwait,
  output logic [WORD_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              dwait,
  output logic [WORD_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic [1:0]        ramstate
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]       icount,
  output logic [31:0]       dcount,
  output logic [31:0]       stallcount
`endif
);

  localparam int unsigned STREAK_W = 4;
  localparam int unsigned STATE_W  = 2;

  localparam logic [STATE_W-1:0] IDLE = 2'd0;
  localparam logic [STATE_W-1:0] DGNT = 2'd1;
  localparam logic [STATE_W-1:0] IGNT = 2'd2;

  localparam logic [1:0] RAM_ACCESS = 2'd2;

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DSTREAK);

  logic [STATE_W-1:0]  state;
  logic [STATE_W-1:0]  next_state;
  logic [STREAK_W-1:0] streak;
  logic [STREAK_W-1:0] next_streak;
  logic                d_req;
  logic                i_done;
  logic                d_done;

  // RAM read data goes straight to both caches; each samples it only when its wait is 0
  assign iload = ramload;
  assign dload = ramload;

  // Owner and starvation-streak registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      streak <= '0;
    end else begin
      state  <= next_state;
      streak <= next_streak;
    end
  end

  // Arbitration, RAM port steering and completion strobes
  always_comb begin
    next_state  = state;
    next_streak = streak;
    iwait       = 1'b1;
    dwait       = 1'b1;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    i_done      = 1'b0;
    d_done      = 1'b0;
    d_req       = dREN | dWEN;

    case (state)
      IDLE: begin
        // the dcache wins unless the icache has waited through a full streak
        if (d_req && !(iREN && (streak == STREAK_MAX))) begin
          next_state = DGNT;
        end else if (iREN) begin
          next_state = IGNT;
        end
      end

      DGNT: begin
        if (!d_req) begin
          // request abandoned: release the port without a strobe
          next_state = IDLE;
        end else begin
          ramaddr  = daddr;
          ramWEN   = dWEN;
          ramREN   = dREN & ~dWEN;
          ramstore = dWEN ? dstore : '0;
          if (ramstate == RAM_ACCESS) begin
            dwait      = 1'b0;
            d_done     = 1'b1;
            next_state = IDLE;
            if (iREN) begin
              next_streak = (streak >= STREAK_MAX) ? STREAK_MAX : streak + STREAK_W'(1);
            end else begin
              next_streak = '0;
            end
          end
        end
      end

      IGNT: begin
        if (!iREN) begin
          next_state = IDLE;
        end else begin
          ramaddr = iaddr;
          ramREN  = 1'b1;
          if (ramstate == RAM_ACCESS) begin
            iwait       = 1'b0;
            i_done      = 1'b1;
            next_state  = IDLE;
            next_streak = '0;
          end
        end
      end

      default: begin
        next_state = IDLE;
      end
    endcase
  end

`ifdef ARB_STATS_EN
  // Completion and icache stall statistics; all three counters wrap at 2^32
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      icount     <= '0;
      dcount     <= '0;
      stallcount <= '0;
    end else begin
      if (i_done) begin
        icount <= icount + 32'd1;
      end
      if (d_done) begin
        dcount <= dcount + 32'd1;
      end
      if (iREN && (state != IGNT)) begin
        stallcount <= stallcount + 32'd1;
      end
    end
  end
`else
  logic unused_done;
  assign unused_done = i_done ^ d_done;
`endif

endmodule
